// File: rtl/fetch_entry_queue_pkg.sv
// Shared types and default sizing for the fetch entry queue.
// Contents:
//   fetch_entry_t    - one fetched instruction slot (pc + raw instruction word)
//   QUEUE_DEPTH      - default queue depth in entries
//   QUEUE_FETCH_NUM  - default max entries pushed per cycle
//   QUEUE_ISSUE_NUM  - default max entries popped per cycle (`ISSUE_NUM, 2 if undefined)
`ifndef ISSUE_NUM
`define ISSUE_NUM 2
`endif

package fetch_entry_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned QUEUE_DEPTH     = 16;
  localparam int unsigned QUEUE_FETCH_NUM = 2;
  localparam int unsigned QUEUE_ISSUE_NUM = `ISSUE_NUM;

endpackage

// File: rtl/fetch_entry_queue_if.sv
// Fetch -> queue -> issue bundle.
// master: the fetch/issue side (drives flush, push_num, push_entry, pop_num)
// slave : the queue (drives push_ready, pop_entry, pop_valid, count, empty)
interface fetch_entry_queue_if #(
  parameter int unsigned DEPTH     = fetch_entry_queue_pkg::QUEUE_DEPTH,
  parameter int unsigned FETCH_NUM = fetch_entry_queue_pkg::QUEUE_FETCH_NUM,
  parameter int unsigned ISSUE_NUM = fetch_entry_queue_pkg::QUEUE_ISSUE_NUM
);

  localparam int unsigned PUSH_W = $clog2(FETCH_NUM + 1);
  localparam int unsigned POP_W  = $clog2(ISSUE_NUM + 1);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic                                                 flush;
  logic [PUSH_W-1:0]                                    push_num;
  fetch_entry_queue_pkg::fetch_entry_t [FETCH_NUM-1:0]  push_entry;
  logic                                                 push_ready;
  logic [POP_W-1:0]                                     pop_num;
  fetch_entry_queue_pkg::fetch_entry_t [ISSUE_NUM-1:0]  pop_entry;
  logic [ISSUE_NUM-1:0]                                 pop_valid;
  logic [CNT_W-1:0]                                     count;
  logic                                                 empty;

  modport master (
    output flush, push_num, push_entry, pop_num,
    input  push_ready, pop_entry, pop_valid, count, empty
  );

  modport slave (
    input  flush, push_num, push_entry, pop_num,
    output push_ready, pop_entry, pop_valid, count, empty
  );

endinterface

// File: rtl/fetch_entry_queue.sv
// Multi-push / multi-pop FIFO between I$ fetch and decode/issue.
// Fetch writes up to FETCH_NUM entries per cycle (all-or-nothing, gated by
// push_ready); issue sees the oldest ISSUE_NUM entries combinationally and
// retires pop_num of them (clamped to what is visible) on the clock edge.
// Ports:
//   clk  - clock, posedge
//   rst  - asynchronous, active-high reset
//   bus  - fetch_entry_queue_if.slave: flush, push_num/push_entry/push_ready,
//          pop_num/pop_entry/pop_valid, count, empty
// Optional feature: FETCH_QUEUE_BYPASS_EN -- when defined, pushes into an empty
// queue are visible on pop_entry in the same cycle (0-cycle latency).
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = QUEUE_DEPTH,
  parameter int unsigned FETCH_NUM = QUEUE_FETCH_NUM,
  parameter int unsigned ISSUE_NUM = QUEUE_ISSUE_NUM
) (
  input  logic               clk,
  input  logic               rst,
  fetch_entry_queue_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned PUSH_W = $clog2(FETCH_NUM + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;

  logic              push_ready_c;
  logic [PUSH_W-1:0] push_acc;
  logic              bypass;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  pop_take;
  logic [CNT_W-1:0]  skip;

  logic [FETCH_NUM-1:0] wr_en;
  logic [PTR_W-1:0]     wr_addr [FETCH_NUM];
  fetch_entry_t         wr_data [FETCH_NUM];

  // Push acceptance, bypass qualification and pop clamping
  always_comb begin
    push_ready_c = (DEPTH - 32'(count_q)) >= FETCH_NUM;
    push_acc     = '0;
    if (push_ready_c) begin
      push_acc = (32'(bus.push_num) > FETCH_NUM) ? PUSH_W'(FETCH_NUM) : bus.push_num;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = !rst && !bus.flush && (count_q == '0) && push_ready_c;
`else
    bypass = 1'b0;
`endif
    // On a bypass the visible entries are the incoming ones, not storage
    avail    = bypass ? CNT_W'(push_acc) : count_q;
    pop_take = (CNT_W'(bus.pop_num) > avail) ? avail : CNT_W'(bus.pop_num);
    // Bypassed entries that issue takes right away are never written
    skip     = bypass ? pop_take : '0;
  end

  // Head-of-queue view presented to issue
  always_comb begin
    bus.pop_entry = '0;
    bus.pop_valid = '0;
    for (int unsigned i = 0; i < ISSUE_NUM; i++) begin
      if (CNT_W'(i) < avail) begin
        bus.pop_valid[i] = 1'b1;
        if (bypass) begin
          if (i < FETCH_NUM) bus.pop_entry[i] = bus.push_entry[i];
        end else begin
          bus.pop_entry[i] = mem[head + PTR_W'(i)];
        end
      end
    end
  end

  // Storage write ports: slot k takes push_entry[k + skip] at tail + k
  always_comb begin
    for (int unsigned k = 0; k < FETCH_NUM; k++) begin
      wr_en[k]   = !bus.flush && ((CNT_W'(k) + skip) < CNT_W'(push_acc));
      wr_addr[k] = tail + PTR_W'(k);
      wr_data[k] = '0;
      for (int unsigned j = 0; j < FETCH_NUM; j++) begin
        if (CNT_W'(j) == (CNT_W'(k) + skip)) wr_data[k] = bus.push_entry[j];
      end
    end
  end

  // Pointer / occupancy next state; flush overrides everything
  always_comb begin
    head_nxt  = head + (bypass ? '0 : PTR_W'(pop_take));
    tail_nxt  = tail + PTR_W'(push_acc) - PTR_W'(skip);
    count_nxt = count_q + CNT_W'(push_acc) - pop_take;
    if (bus.flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head_nxt;
      tail    <= tail_nxt;
      count_q <= count_nxt;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < FETCH_NUM; k++) begin
      if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
    end
  end

  assign bus.push_ready = push_ready_c;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);

endmodule

// File: tb/tb_fetch_entry_queue.sv
module tb_fetch_entry_queue;
  import fetch_entry_queue_pkg::*;

  localparam int unsigned DEPTH     = QUEUE_DEPTH;
  localparam int unsigned FETCH_NUM = QUEUE_FETCH_NUM;
  localparam int unsigned ISSUE_NUM = QUEUE_ISSUE_NUM;

  logic clk;
  logic rst;

  fetch_entry_queue_if bus ();

  fetch_entry_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total  = 0;
  int  passed = 0;
  bit  chk_en = 0;

  fetch_entry_t model_q [$];
  fetch_entry_t pushed  [$];
  fetch_entry_t vis     [$];
  int           m_n;
  int           m_take;
  bit           m_ready;
  bit           m_byp;

  function automatic fetch_entry_t mk(int n);
    fetch_entry_t e;
    e.pc    = 32'h0000_1000 + 32'(n) * 32'd4;
    e.instr = 32'hA000_0000 + 32'(n);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: a plain queue; outputs are its head, next state is
  // (queue ++ accepted pushes) minus the entries issue was able to take.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      model_q.delete();
    end else begin
      m_n     = model_q.size();
      m_ready = (int'(DEPTH) - m_n) >= int'(FETCH_NUM);
      pushed.delete();
      if (m_ready)
        for (int k = 0; k < int'(bus.push_num) && k < int'(FETCH_NUM); k++)
          pushed.push_back(bus.push_entry[k]);
      m_byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
      m_byp = (m_n == 0) && m_ready && !bus.flush;
`endif
      if (m_byp) vis = pushed;
      else       vis = model_q;
      if (chk_en) begin
        chk("count", 64'(bus.count), 64'(m_n));
        chk("push_ready", 64'(bus.push_ready), 64'(m_ready));
        chk("empty", 64'(bus.empty), 64'(m_n == 0));
        for (int i = 0; i < int'(ISSUE_NUM); i++) begin
          chk("pop_valid", 64'(bus.pop_valid[i]), 64'(i < vis.size()));
          chk("pop_entry", 64'(bus.pop_entry[i]), (i < vis.size()) ? 64'(vis[i]) : 64'd0);
        end
      end
      if (bus.flush) begin
        model_q.delete();
      end else begin
        m_take = (int'(bus.pop_num) < vis.size()) ? int'(bus.pop_num) : vis.size();
        foreach (pushed[k]) model_q.push_back(pushed[k]);
        repeat (m_take) void'(model_q.pop_front());
      end
    end
  end

  task automatic drive(int pn, fetch_entry_t e0, fetch_entry_t e1, int qn, bit fl);
    @(negedge clk);
    bus.push_num      = 2'(pn);
    bus.push_entry[0] = e0;
    bus.push_entry[1] = e1;
    bus.pop_num       = 2'(qn);
    bus.flush         = fl;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.push_num = '0;
    bus.push_entry = '0;
    bus.pop_num = '0;
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_push_ready", 64'(bus.push_ready), 64'd1);
    chk("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
    chk("rst_pop_entry0", 64'(bus.pop_entry[0]), 64'd0);
    idle();
    rst = 1'b0;
    chk_en = 1;

    // Ordering
    drive(2, mk(1), mk(2), 0, 0);
    drive(2, mk(3), mk(4), 0, 0);
    drive(0, '0, '0, 2, 0);
    #3;
    chk("ord_count4", 64'(bus.count), 64'd4);
    chk("ord_A", 64'(bus.pop_entry[0]), 64'h0000_1004_A000_0001);
    chk("ord_B", 64'(bus.pop_entry[1]), 64'h0000_1008_A000_0002);
    drive(0, '0, '0, 2, 0);
    #3;
    chk("ord_count2", 64'(bus.count), 64'd2);
    chk("ord_C", 64'(bus.pop_entry[0]), 64'h0000_100C_A000_0003);
    chk("ord_D", 64'(bus.pop_entry[1]), 64'h0000_1010_A000_0004);
    idle();
    #3;
    chk("ord_count0", 64'(bus.count), 64'd0);

    // Fill to full, drop the 9th push, free space with one pop
    for (int c = 0; c < 8; c++) drive(2, mk(10 + 2 * c), mk(11 + 2 * c), 0, 0);
    drive(2, mk(90), mk(91), 0, 0);
    #3;
    chk("full_count", 64'(bus.count), 64'd16);
    chk("full_ready", 64'(bus.push_ready), 64'd0);
    drive(0, '0, '0, 2, 0);
    #3;
    chk("full_hold", 64'(bus.count), 64'd16);
    chk("full_head", 64'(bus.pop_entry[0]), 64'(mk(10)));
    idle();
    #3;
    chk("after_pop_count", 64'(bus.count), 64'd14);
    chk("after_pop_ready", 64'(bus.push_ready), 64'd1);
    chk("after_pop_head", 64'(bus.pop_entry[0]), 64'(mk(12)));
    for (int c = 0; c < 7; c++) drive(0, '0, '0, 2, 0);

    // Simultaneous push/pop at count 3, then clamp at count 1
    drive(2, mk(40), mk(41), 0, 0);
    drive(1, mk(42), '0, 0, 0);
    drive(2, mk(43), mk(44), 2, 0);
    #3;
    chk("sim_count3", 64'(bus.count), 64'd3);
    chk("sim_head40", 64'(bus.pop_entry[0]), 64'(mk(40)));
    drive(0, '0, '0, 2, 0);
    #3;
    chk("sim_count_after", 64'(bus.count), 64'd3);
    chk("sim_head42", 64'(bus.pop_entry[0]), 64'(mk(42)));
    chk("sim_next43", 64'(bus.pop_entry[1]), 64'(mk(43)));
    drive(0, '0, '0, 2, 0);
    #3;
    chk("clamp_count1", 64'(bus.count), 64'd1);
    idle();
    #3;
    chk("clamp_count0", 64'(bus.count), 64'd0);
    chk("clamp_empty", 64'(bus.empty), 64'd1);

    // Random traffic across the pointer wrap
    for (int c = 0; c < 40; c++)
      drive(int'($urandom_range(0, 2)), mk(100 + 2 * c), mk(101 + 2 * c),
            int'($urandom_range(0, 2)), 0);

    // Flush at count 7 with a concurrent push
    drive(0, '0, '0, 0, 1);
    drive(2, mk(50), mk(51), 0, 0);
    drive(2, mk(52), mk(53), 0, 0);
    drive(2, mk(54), mk(55), 0, 0);
    drive(1, mk(56), '0, 0, 0);
    drive(2, mk(200), mk(201), 1, 1);
    #3;
    chk("flush_count7", 64'(bus.count), 64'd7);
    idle();
    #3;
    chk("flush_count0", 64'(bus.count), 64'd0);
    chk("flush_empty", 64'(bus.empty), 64'd1);
    chk("flush_valid", 64'(bus.pop_valid), 64'd0);
    drive(1, mk(210), '0, 0, 0);
    idle();
    #3;
    chk("post_flush_head", 64'(bus.pop_entry[0]), 64'(mk(210)));
    drive(0, '0, '0, 1, 0);

    // Asynchronous reset mid-traffic at count 5
    drive(2, mk(60), mk(61), 0, 0);
    drive(2, mk(62), mk(63), 0, 0);
    drive(1, mk(64), '0, 0, 0);
    drive(2, mk(65), mk(66), 1, 0);
    #1;
    chk("pre_rst_count5", 64'(bus.count), 64'd5);
    rst = 1'b1;
    #0.5;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_valid", 64'(bus.pop_valid), 64'd0);
    chk("arst_ready", 64'(bus.push_ready), 64'd1);
    idle();
    rst = 1'b0;
    idle();

    // Push A,B into an empty queue while issue takes one
    drive(2, mk(70), mk(71), 1, 0);
    #3;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_A", 64'(bus.pop_entry[0]), 64'(mk(70)));
    chk("byp_same_valid", 64'(bus.pop_valid), 64'd3);
`else
    chk("nobyp_same_valid", 64'(bus.pop_valid), 64'd0);
`endif
    idle();
    #3;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_next_count", 64'(bus.count), 64'd1);
    chk("byp_next_B", 64'(bus.pop_entry[0]), 64'(mk(71)));
`else
    chk("nobyp_next_count", 64'(bus.count), 64'd2);
    chk("nobyp_next_A", 64'(bus.pop_entry[0]), 64'(mk(70)));
`endif
    drive(0, '0, '0, 2, 0);
    idle();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
